// File: rtl/vga_line_fetch_arbiter.sv
// Single-port video RAM arbiter: prefetches the next visible 1 bpp line into the
// line buffer during horizontal blanking and serves CPU accesses while idle.
module vga_line_fetch_arbiter #(
   parameter int H_ACTIVE       = 640,
   parameter int H_TOTAL        = 800,
   parameter int V_ACTIVE       = 480,
   parameter int V_TOTAL        = 525,
   parameter int BYTES_PER_LINE = 80,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int LB_AW          = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       h_count,
   input  logic [15:0]       v_count,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              fetch_busy,
   output logic              line_ready,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // The whole fetch (trigger, 80 reads, drain) must finish inside blanking.
   localparam bit FETCH_FITS = (H_ACTIVE + BYTES_PER_LINE + 2) <= H_TOTAL;
   localparam logic [LB_AW-1:0] LAST_IDX = LB_AW'(BYTES_PER_LINE - 1);

   state_t              state_q, state_d;
   logic [LB_AW-1:0]    idx_q, idx_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                rd_phase_q, rd_phase_d;
   logic                cpu_rvalid_q, cpu_rvalid_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                lb_we_q, lb_we_d;
   logic [LB_AW-1:0]    lb_addr_q, lb_addr_d;
   logic                line_ready_q, line_ready_d;

   logic [15:0]         next_line;
   logic [ADDR_W-1:0]   base_addr;
   logic                fetch_trigger;

   assign next_line     = (v_count == 16'(V_TOTAL - 1)) ? 16'd0 : v_count + 16'd1;
   assign base_addr     = ADDR_W'(32'(next_line) * BYTES_PER_LINE);
   assign fetch_trigger = FETCH_FITS && (state_q == IDLE) &&
                          (h_count == 16'(H_ACTIVE)) && (next_line < 16'(V_ACTIVE));

   // Handshake: cpu_req is held until a one-cycle cpu_ack; a grant requires
   // cpu_ack low, so a held request is never granted twice.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_ack_d    = 1'b0;
      lb_we_d      = 1'b0;
      lb_addr_d    = lb_addr_q;
      line_ready_d = 1'b0;
      // In IDLE any active strobe belongs to the CPU; its read data lands a cycle later.
      rd_phase_d   = (state_q == IDLE) && mem_en_q && !mem_we_q;
      cpu_rvalid_d = rd_phase_q;
      cpu_rdata_d  = rd_phase_q ? mem_rdata : cpu_rdata_q;

      case (state_q)
         IDLE: begin
            if (fetch_trigger) begin
               state_d    = FETCH;
               idx_d      = '0;
               mem_en_d   = 1'b1;
               mem_addr_d = base_addr;
            end else if (cpu_req && !cpu_ack_q) begin
               mem_en_d    = 1'b1;
               mem_we_d    = cpu_we;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               cpu_ack_d   = 1'b1;
            end
         end
         FETCH: begin
            lb_we_d   = 1'b1;
            lb_addr_d = idx_q;
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               idx_d      = idx_q + LB_AW'(1);
               mem_en_d   = 1'b1;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            state_d      = IDLE;
            line_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         rd_phase_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         lb_we_q      <= 1'b0;
         lb_addr_q    <= '0;
         line_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         rd_phase_q   <= rd_phase_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         lb_we_q      <= lb_we_d;
         lb_addr_q    <= lb_addr_d;
         line_ready_q <= line_ready_d;
      end
   end

   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign lb_we      = lb_we_q;
   assign lb_addr    = lb_addr_q;
   assign lb_wdata   = mem_rdata;
   assign line_ready = line_ready_q;
   assign fetch_busy = (state_q != IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
// Bench for vga_line_fetch_arbiter: synchronous RAM model, line-fetch and CPU
// access expectations computed from line/address arithmetic and a shadow memory.
module tb_vga_line_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] h_count, v_count;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'd0;
   logic        lb_we;
   logic [6:0]  lb_addr;
   logic [7:0]  lb_wdata;
   logic        fetch_busy, line_ready;
   logic [1:0]  dbg_state;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  seed;
   logic [7:0]  ram [int];
   logic [7:0]  ref_mem [int];
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;

   vga_line_fetch_arbiter dut (
      .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
      .fetch_busy(fetch_busy), .line_ready(line_ready), .dbg_state(dbg_state)
   );

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      return 8'((a * 16'd37) ^ (a >> 7)) ^ seed;
   endfunction

   function automatic logic [7:0] ref_val(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
   endfunction

   // Synchronous single-port RAM: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we) ram[int'(mem_addr)] = mem_wdata;
         else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_byte(mem_addr);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_cmp++;
         if ({cpu_ack, cpu_rvalid, mem_en, mem_we, lb_we, fetch_busy, line_ready,
              cpu_rdata, mem_addr, mem_wdata, lb_addr, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs cyc=%0d: ack=%b en=%b addr=%h lb_we=%b busy=%b rdy=%b, want all 0",
                     i, cpu_ack, mem_en, mem_addr, lb_we, fetch_busy, line_ready);
         end
      end
      rst = 1'b0;
      cycle();
      n_cmp++;
      if (cpu_ack !== 1'b1 || mem_en !== 1'b1 || mem_addr !== cpu_addr) begin
         n_err++;
         $display("FAIL reset_release_ack: ack=%b en=%b addr=%h, want 1 1 %h", cpu_ack, mem_en, mem_addr, cpu_addr);
      end
      cpu_req = 1'b0;
      cycle();
      cycle();
      n_cmp++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_val(cpu_addr)) begin
         n_err++;
         $display("FAIL reset_release_read: rvalid=%b rdata=%h, want 1 %h", cpu_rvalid, cpu_rdata, ref_val(cpu_addr));
      end
      cycle();
   endtask

   task automatic test_fetch(input int v);
      int nl;
      logic do_fetch, exp_bit;
      logic [15:0] base;
      logic [7:0] want;
      nl = (v == 524) ? 0 : v + 1;
      do_fetch = (nl < 480);
      base = 16'(nl * 80);
      exp_q.delete();
      if (do_fetch) for (int i = 0; i < 80; i++) exp_q.push_back(ref_val(base + 16'(i)));
      v_count = 16'(v); h_count = 16'd640; cpu_req = 1'b0;
      for (int c = 0; c < 90; c++) begin
         cycle();
         h_count = h_count + 16'd1;
         exp_bit = do_fetch && (c < 80);
         n_cmp++;
         if (mem_en !== exp_bit) begin
            n_err++; $display("FAIL fetch_mem_en v=%0d c=%0d: got %b want %b", v, c, mem_en, exp_bit);
         end
         if (exp_bit) begin
            n_cmp++;
            if (mem_addr !== base + 16'(c) || mem_we !== 1'b0) begin
               n_err++; $display("FAIL fetch_addr v=%0d c=%0d: got %h we=%b want %h we=0", v, c, mem_addr, mem_we, base + 16'(c));
            end
         end
         exp_bit = do_fetch && (c >= 1) && (c <= 80);
         n_cmp++;
         if (lb_we !== exp_bit) begin
            n_err++; $display("FAIL fetch_lb_we v=%0d c=%0d: got %b want %b", v, c, lb_we, exp_bit);
         end
         if (exp_bit) begin
            n_cmp++;
            if (lb_addr !== 7'(c - 1)) begin
               n_err++; $display("FAIL fetch_lb_addr v=%0d c=%0d: got %0d want %0d", v, c, lb_addr, c - 1);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL fetch_lb_extra v=%0d c=%0d: got write, want none left", v, c);
            end else begin
               want = exp_q.pop_front();
               if (lb_wdata !== want) begin
                  n_err++; $display("FAIL fetch_lb_data v=%0d c=%0d: got %h want %h", v, c, lb_wdata, want);
               end
            end
         end
         exp_bit = do_fetch && (c == 81);
         n_cmp++;
         if (line_ready !== exp_bit) begin
            n_err++; $display("FAIL fetch_line_ready v=%0d c=%0d: got %b want %b", v, c, line_ready, exp_bit);
         end
         exp_bit = do_fetch && (c <= 80);
         n_cmp++;
         if (fetch_busy !== exp_bit) begin
            n_err++; $display("FAIL fetch_busy v=%0d c=%0d: got %b want %b", v, c, fetch_busy, exp_bit);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL fetch_lb_missing v=%0d: got %0d bytes unwritten want 0", v, exp_q.size());
      end
      h_count = 16'd0;
   endtask

   task automatic test_cpu_idle();
      logic we;
      logic [15:0] a;
      logic [7:0] d;
      h_count = 16'd100; v_count = 16'd10;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) begin we = 1'b1; a = 16'h1234; d = 8'hA5; end
         else if (k == 1) begin we = 1'b0; a = 16'h1234; d = 8'h00; end
         else begin we = 1'($urandom_range(0, 1)); a = 16'h1230 + 16'($urandom_range(0, 7)); d = 8'($urandom); end
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
         cycle();
         n_cmp++;
         if (cpu_ack !== 1'b1 || mem_en !== 1'b1 || mem_we !== we || mem_addr !== a || (we && mem_wdata !== d)) begin
            n_err++;
            $display("FAIL cpu_grant k=%0d: ack=%b en=%b we=%b addr=%h wd=%h, want 1 1 %b %h %h",
                     k, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, we, a, d);
         end
         cpu_req = 1'b0;
         cycle();
         n_cmp++;
         if (cpu_ack !== 1'b0 || mem_en !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL cpu_gap k=%0d: ack=%b en=%b rvalid=%b, want 0 0 0", k, cpu_ack, mem_en, cpu_rvalid);
         end
         cycle();
         n_cmp++;
         if (cpu_rvalid !== !we || (!we && cpu_rdata !== ref_val(a))) begin
            n_err++; $display("FAIL cpu_rdata k=%0d: rvalid=%b rdata=%h, want %b %h", k, cpu_rvalid, cpu_rdata, !we, ref_val(a));
         end
         if (we) ref_mem[int'(a)] = d;
      end
      h_count = 16'd0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      logic [7:0] d;
      h_count = 16'd200;
      a = 16'($urandom); d = 8'($urandom);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      cycle();
      n_cmp++;
      if (cpu_ack !== 1'b1 || mem_addr !== a) begin
         n_err++; $display("FAIL b2b_first: ack=%b addr=%h, want 1 %h", cpu_ack, mem_addr, a);
      end
      ref_mem[int'(a)] = d;
      for (int k = 1; k < 4; k++) begin
         a = 16'($urandom); d = 8'($urandom);
         cpu_addr = a; cpu_wdata = d;
         cycle();
         n_cmp++;
         if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin
            n_err++; $display("FAIL b2b_gap k=%0d: ack=%b en=%b, want 0 0", k, cpu_ack, mem_en);
         end
         cycle();
         n_cmp++;
         if (cpu_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
            n_err++; $display("FAIL b2b_grant k=%0d: ack=%b we=%b addr=%h wd=%h, want 1 1 %h %h", k, cpu_ack, mem_we, mem_addr, mem_wdata, a, d);
         end
         ref_mem[int'(a)] = d;
      end
      cpu_req = 1'b0;
      cycle();
      cycle();
      h_count = 16'd0;
   endtask

   task automatic test_contention();
      int v, nl, acks;
      logic [15:0] base, a;
      logic [7:0] d;
      v = $urandom_range(0, 478); nl = v + 1; base = 16'(nl * 80);
      a = 16'($urandom); d = 8'($urandom);
      acks = 0;
      v_count = 16'(v); h_count = 16'd640;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      for (int c = 0; c < 86; c++) begin
         cycle();
         h_count = h_count + 16'd1;
         if (c < 80) begin
            n_cmp++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== base + 16'(c)) begin
               n_err++; $display("FAIL cont_fetch c=%0d: en=%b we=%b addr=%h, want 1 0 %h", c, mem_en, mem_we, mem_addr, base + 16'(c));
            end
         end
         n_cmp++;
         if (cpu_ack !== (c == 82)) begin
            n_err++; $display("FAIL cont_ack c=%0d: got %b want %b", c, cpu_ack, (c == 82));
         end
         if (cpu_ack === 1'b1) begin
            acks++;
            n_cmp++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
               n_err++; $display("FAIL cont_grant: en=%b we=%b addr=%h wd=%h, want 1 1 %h %h", mem_en, mem_we, mem_addr, mem_wdata, a, d);
            end
            cpu_req = 1'b0;
         end
      end
      n_cmp++;
      if (acks != 1) begin
         n_err++; $display("FAIL cont_ack_count: got %0d want 1", acks);
      end
      cpu_req = 1'b0;
      ref_mem[int'(a)] = d;
      h_count = 16'd0;
   endtask

   task automatic test_reset_mid_fetch(input int k);
      int v, hits;
      logic [15:0] base;
      v = $urandom_range(0, 478); base = 16'((v + 1) * 80);
      v_count = 16'(v); h_count = 16'd640; cpu_req = 1'b0;
      for (int c = 0; c <= k; c++) begin
         cycle();
         h_count = h_count + 16'd1;
      end
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== base + 16'(k)) begin
         n_err++; $display("FAIL rstmid_pre k=%0d: en=%b addr=%h, want 1 %h", k, mem_en, mem_addr, base + 16'(k));
      end
      rst = 1'b1;
      cycle();
      h_count = h_count + 16'd1;
      n_cmp++;
      if (mem_en !== 1'b0 || lb_we !== 1'b0 || fetch_busy !== 1'b0 || line_ready !== 1'b0 || dbg_state !== 2'd0) begin
         n_err++; $display("FAIL rstmid_abort k=%0d: en=%b lb_we=%b busy=%b rdy=%b st=%0d, want 0 0 0 0 0",
                           k, mem_en, lb_we, fetch_busy, line_ready, dbg_state);
      end
      rst = 1'b0;
      hits = 0;
      for (int c = 0; c < 90; c++) begin
         cycle();
         h_count = h_count + 16'd1;
         if (mem_en === 1'b1 || lb_we === 1'b1 || line_ready === 1'b1) hits++;
      end
      n_cmp++;
      if (hits != 0) begin
         n_err++; $display("FAIL rstmid_quiet k=%0d: got %0d active cycles want 0", k, hits);
      end
      h_count = 16'd0;
   endtask

   initial begin
      seed = 8'($urandom);
      rst = 1'b1; h_count = 16'd0; v_count = 16'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;
      test_reset();
      test_fetch(0);
      test_fetch(524);
      test_fetch(479);
      test_fetch($urandom_range(1, 477));
      test_fetch($urandom_range(480, 523));
      test_cpu_idle();
      test_back_to_back();
      test_contention();
      test_fetch(478);
      test_reset_mid_fetch(40);
      test_reset_mid_fetch($urandom_range(1, 78));
      test_fetch($urandom_range(0, 477));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
